// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Purpose  : Shared geometry constants, FSM state encoding and word-select
//            helper for the direct-mapped write-back cache controller.
// Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

  localparam int TAG_W  = 4;
  localparam int IDX_W  = 4;
  localparam int OFF_W  = 2;
  localparam int DATA_W = 32;
  localparam int LINES  = 16;
  localparam int WORDS  = 4;
  localparam int LINE_W = WORDS * DATA_W;
  localparam int ADDR_W = TAG_W + IDX_W + OFF_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    REFILL    = 2'd3
  } state_t;

  // Pick one 32-bit word out of a flattened 4-word line (word 0 in the LSBs).
  function automatic logic [DATA_W-1:0] get_word(input logic [LINE_W-1:0] line,
                                                 input logic [OFF_W-1:0]  sel);
    return line[int'(sel)*DATA_W +: DATA_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_line_store.sv
`default_nettype none
// ============================================================================
// Module   : cache_line_store
// Purpose  : Tag / valid / dirty / data storage for 16 lines of 4 words.
//            One combinational line read port, one word write port and one
//            metadata (tag, valid, dirty) write port.
// Revision : 1.0 - initial release
// ============================================================================
module cache_line_store
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  // read port: whole line plus metadata
  input  logic [IDX_W-1:0]  rd_index,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [LINE_W-1:0] rd_line,
  // word write port
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [OFF_W-1:0]  wr_word,
  input  logic [DATA_W-1:0] wr_data,
  // metadata write port
  input  logic              meta_en,
  input  logic [IDX_W-1:0]  meta_index,
  input  logic [TAG_W-1:0]  meta_tag,
  input  logic              meta_valid,
  input  logic              meta_dirty
);

  logic [DATA_W-1:0] data_mem [LINES][WORDS];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid_bits;
  logic [LINES-1:0]  dirty_bits;

  assign rd_tag   = tag_mem[rd_index];
  assign rd_valid = valid_bits[rd_index];
  assign rd_dirty = dirty_bits[rd_index];

  for (genvar w = 0; w < WORDS; w++) begin : g_rd_word
    assign rd_line[w*DATA_W +: DATA_W] = data_mem[rd_index][w];
  end

  // Valid and dirty flags are the only state that must come up cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (meta_en) begin
      valid_bits[meta_index] <= meta_valid;
      dirty_bits[meta_index] <= meta_dirty;
    end
  end

  // Tag and data arrays carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_index][wr_word] <= wr_data;
    end
    if (meta_en) begin
      tag_mem[meta_index] <= meta_tag;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl
// Purpose  : Direct-mapped, write-back, write-allocate cache controller with
//            a four-state FSM (IDLE, COMPARE, WRITEBACK, REFILL) and a
//            beat-wise backing-memory interface.
// Revision : 1.0 - initial release
// ============================================================================
module cache_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [TAG_W-1:0]  tag,
  input  logic [IDX_W-1:0]  index,
  input  logic [OFF_W-1:0]  blk_offset,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  state_t            state;
  logic [OFF_W-1:0]  beat;
  logic [OFF_W-1:0]  next_beat;
  logic              beat_done;

  logic [TAG_W-1:0]  lat_tag;
  logic [IDX_W-1:0]  lat_index;
  logic [OFF_W-1:0]  lat_off;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;

  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid;
  logic              rd_dirty;
  logic [LINE_W-1:0] rd_line;
  logic              hit;

  logic              wr_en;
  logic [OFF_W-1:0]  wr_word;
  logic [DATA_W-1:0] wr_data;
  logic              meta_en;
  logic [TAG_W-1:0]  meta_tag;
  logic              meta_dirty;

  assign next_beat = beat + 2'd1;
  assign beat_done = mem_req && mem_ack;
  assign hit       = rd_valid && (rd_tag == lat_tag);

  cache_line_store u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_index   (lat_index),
    .rd_tag     (rd_tag),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_line    (rd_line),
    .wr_en      (wr_en),
    .wr_index   (lat_index),
    .wr_word    (wr_word),
    .wr_data    (wr_data),
    .meta_en    (meta_en),
    .meta_index (lat_index),
    .meta_tag   (meta_tag),
    .meta_valid (1'b1),
    .meta_dirty (meta_dirty)
  );

  // Storage write strobes: store hits, refill beats, and line-status updates.
  always_comb begin
    wr_en      = 1'b0;
    wr_word    = lat_off;
    wr_data    = lat_wdata;
    meta_en    = 1'b0;
    meta_tag   = lat_tag;
    meta_dirty = 1'b0;
    case (state)
      COMPARE: begin
        if (hit && lat_we) begin
          wr_en      = 1'b1;
          meta_en    = 1'b1;
          meta_dirty = 1'b1;
        end
      end
      WRITEBACK: begin
        // Old line is now clean in memory; keep its tag until refill retags.
        if (beat_done && beat == 2'd3) begin
          meta_en  = 1'b1;
          meta_tag = rd_tag;
        end
      end
      REFILL: begin
        if (beat_done) begin
          wr_en   = 1'b1;
          wr_word = beat;
          wr_data = mem_rdata;
          meta_en = (beat == 2'd3);
        end
      end
      default: ;
    endcase
  end

  // Main controller FSM; every external output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat       <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      lat_tag    <= '0;
      lat_index  <= '0;
      lat_off    <= '0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_tag   <= tag;
            lat_index <= index;
            lat_off   <= blk_offset;
            lat_we    <= req_we;
            lat_wdata <= req_wdata;
            req_ready <= 1'b0;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            resp_valid <= 1'b1;
            resp_rdata <= lat_we ? '0 : get_word(rd_line, lat_off);
            req_ready  <= 1'b1;
            state      <= IDLE;
          end else if (rd_valid && rd_dirty) begin
            beat      <= '0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {rd_tag, lat_index, 2'd0};
            mem_wdata <= get_word(rd_line, 2'd0);
            state     <= WRITEBACK;
          end else begin
            beat      <= '0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {lat_tag, lat_index, 2'd0};
            mem_wdata <= '0;
            state     <= REFILL;
          end
        end
        WRITEBACK: begin
          if (beat_done) begin
            if (beat == 2'd3) begin
              // Go straight into refill; mem_req stays high across the switch.
              beat      <= '0;
              mem_we    <= 1'b0;
              mem_addr  <= {lat_tag, lat_index, 2'd0};
              mem_wdata <= '0;
              state     <= REFILL;
            end else begin
              beat      <= next_beat;
              mem_addr  <= {rd_tag, lat_index, next_beat};
              mem_wdata <= get_word(rd_line, next_beat);
            end
          end
        end
        REFILL: begin
          if (beat_done) begin
            if (beat == 2'd3) begin
              beat     <= '0;
              mem_req  <= 1'b0;
              mem_addr <= '0;
              state    <= COMPARE;
            end else begin
              beat     <= next_beat;
              mem_addr <= {lat_tag, lat_index, next_beat};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 clk  in  1  single system clock; all state changes on its rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 req_valid  in  1  CPU access request, qualified by req_ready.
REQ-004 req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
REQ-005 tag  in  4  address tag from the decode stage.
REQ-006 index  in  4  line select, 16 lines.
REQ-007 blk_offset  in  2  word within the 4-word block.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_wdata  in  32  store data.
REQ-010 resp_valid  out  1  one-cycle pulse when the access completes.
REQ-011 resp_rdata  out  32  load data, valid with resp_valid; 0 otherwise.
REQ-012 mem_req  out  1  backing-memory beat request, held until mem_ack.
REQ-013 mem_we  out  1  1 = writeback beat, 0 = refill beat.
REQ-014 mem_addr  out  10  word address {tag, index, beat}.
REQ-015 mem_wdata  out  32  writeback data.
REQ-016 mem_rdata  in  32  refill data, valid with mem_ack.
REQ-017 mem_ack  in  1  beat complete; ignored while mem_req = 0.

Function
REQ-018 The block SHALL be a direct-mapped, write-back, write-allocate cache with 16 lines of 4 x 32-bit words, plus a 4-bit tag, a valid bit and a dirty bit per line.
REQ-019 The FSM SHALL have exactly four states: IDLE, COMPARE, WRITEBACK and REFILL.
REQ-020 On acceptance, the block SHALL latch tag, index, blk_offset, req_we and req_wdata, then go to COMPARE on the next cycle.
REQ-021 A COMPARE hit (valid && stored tag == latched tag) SHALL:
  - on a load, drive resp_rdata = word[blk_offset] with resp_valid = 1;
  - on a store, write the word, set dirty and pulse resp_valid;
  - in either case, return to IDLE.
  Hit latency is therefore 2 cycles from acceptance to resp_valid.
REQ-022 A COMPARE miss on a valid, dirty line SHALL go to WRITEBACK; any other miss SHALL go to REFILL.
REQ-023 WRITEBACK SHALL issue beats 0..3 with mem_we = 1, mem_addr = {stored tag, index, beat} and mem_wdata = word[beat], advancing the beat on each mem_ack; after beat 3 it SHALL clear dirty and go to REFILL.
REQ-024 REFILL SHALL issue beats 0..3 with mem_we = 0 and mem_addr = {latched tag, index, beat}, storing mem_rdata into word[beat] on each mem_ack.
REQ-025 After refill beat 3, the block SHALL set valid, write the new tag, clear dirty and return to COMPARE, which then hits.
REQ-026 mem_req, mem_addr, mem_we and mem_wdata SHALL be stable from assertion until mem_ack; mem_req MAY stay high across consecutive beats.
REQ-027 req_valid outside IDLE SHALL be ignored; requests are not queued.
REQ-028 resp_valid SHALL never be high in the same cycle as mem_req.

Reset
REQ-029 rst_n low SHALL immediately force:
  - state to IDLE and beat to 0;
  - all valid and dirty bits to 0;
  - all outputs to 0, except req_ready, which SHALL be 1 once rst_n is deasserted.
REQ-030 Tag and data arrays need no reset.
REQ-031 Reset during WRITEBACK or REFILL SHALL abandon the transfer: mem_req drops asynchronously and no response is issued.

Structure
REQ-032 Package cache_pkg SHALL hold:
  - TAG_W = 4, IDX_W = 4, OFF_W = 2, DATA_W = 32, LINES = 16, WORDS = 4;
  - the FSM state enum.
REQ-033 Tag, valid, dirty and data storage SHALL sit in sub-module cache_line_store: one read port, one word-write port, and a metadata write port.

Verification
REQ-034 After reset, load tag = 3, idx = 5, off = 2 -> 4 refill beats at addrs 0x0D4..0x0D7; resp_rdata = third refill word; 0 writeback beats.
REQ-035 Repeat that load -> resp_valid 2 cycles after acceptance, no mem_req.
REQ-036 Store 0xDEADBEEF to tag 3, idx 5, off 0, then load tag 7, idx 5, off 0 ->
  - writeback beats to 0x0D4..0x0D7, beat 0 carrying 0xDEADBEEF;
  - then refill beats to 0x1D4..0x1D7.
REQ-037 mem_ack delayed 5 cycles per beat -> mem_addr and mem_req held stable throughout; req_ready = 0 until completion.
REQ-038 rst_n pulsed low during refill beat 2 -> mem_req = 0 at once; a following load to the same line misses and refills.
REQ-039 req_valid asserted during REFILL -> not accepted, no extra resp_valid.
